// File: rtl/input_debounce3.sv
// Three-channel switch debouncer: each raw input is synchronized, then must
// differ from its debounced level for DEBOUNCE_CYCLES consecutive samples to toggle it.
module input_debounce3 #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [2:0] db,
    output logic [2:0] rise,
    output logic [2:0] fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       differ;
    logic [2:0]       expire;
    logic [2:0]       db_next;
    logic [CNT_W-1:0] cnt      [3];
    logic [CNT_W-1:0] cnt_next [3];

    assign raw = {c, b, a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Any sample that agrees with the debounced level discards the partial count.
    always_comb begin
        differ   = '0;
        expire   = '0;
        cnt_next = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            differ[i] = s2[i] ^ db[i];
            expire[i] = differ[i] && (cnt[i] == CNT_MAX);
            if (differ[i] && !expire[i]) begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
        db_next = db ^ expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
            db   <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= cnt_next[i];
            end
            db   <= db_next;
            rise <= expire & s2;
            fall <= expire & ~s2;
        end
    end

endmodule

// File: tb/tb_input_debounce3.sv
// Bench for input_debounce3: a sample-history model checked every cycle,
// plus directed sequences with hand-computed edge-by-edge expectations.
module tb_input_debounce3;

    localparam int DC = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       a     = 1'b0;
    logic       b     = 1'b0;
    logic       c     = 1'b0;
    logic [2:0] db;
    logic [2:0] rise;
    logic [2:0] fall;

    int checks = 0;
    int errors = 0;

    input_debounce3 #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .c    (c),
        .db   (db),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;

    // Model: the synchronized view of an input is its value two edges ago; a
    // level changes once DC successive synchronized samples all disagree with it.
    logic [2:0] m_pipe1 = '0;
    logic [2:0] m_pipe2 = '0;
    logic [2:0] m_db    = '0;
    logic [2:0] m_rise  = '0;
    logic [2:0] m_fall  = '0;
    logic [2:0] seen;
    int         streak [3] = '{0, 0, 0};

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pipe1 = '0;
                m_pipe2 = '0;
                m_db    = '0;
                m_rise  = '0;
                m_fall  = '0;
                streak  = '{0, 0, 0};
            end else begin
                seen    = m_pipe2;
                m_pipe2 = m_pipe1;
                m_pipe1 = {c, b, a};
                m_rise  = '0;
                m_fall  = '0;
                for (int i = 0; i < 3; i++) begin
                    streak[i] = (seen[i] != m_db[i]) ? streak[i] + 1 : 0;
                    if (streak[i] == DC) begin
                        m_db[i]   = seen[i];
                        m_rise[i] = seen[i];
                        m_fall[i] = ~seen[i];
                        streak[i] = 0;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_db", db, m_db);
        checkOutput("model_rise", rise, m_rise);
        checkOutput("model_fall", fall, m_fall);
    end

    task automatic applyStimulus(input logic [2:0] cba);
        @(negedge clk);
        {c, b, a} = cba;
    endtask

    task automatic stepCheck(input string name, input logic [2:0] eDb,
                             input logic [2:0] eRise, input logic [2:0] eFall);
        @(posedge clk);
        #1;
        checkOutput({name, "_db"}, db, eDb);
        checkOutput({name, "_rise"}, rise, eRise);
        checkOutput({name, "_fall"}, fall, eFall);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_db", db, 3'b000);
        checkOutput("reset_rise", rise, 3'b000);
        checkOutput("reset_fall", fall, 3'b000);

        // Single channel latency
        applyStimulus(3'b000);
        applyStimulus(3'b001);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) stepCheck("lat_a_wait", 3'b000, 3'b000, 3'b000);
        stepCheck("lat_a_edge6", 3'b001, 3'b001, 3'b000);
        stepCheck("lat_a_edge7", 3'b001, 3'b000, 3'b000);

        // Short pulse on b is rejected
        applyStimulus(3'b011);
        for (int k = 1; k <= 3; k++) stepCheck("glitch_b_hi", 3'b001, 3'b000, 3'b000);
        applyStimulus(3'b001);
        for (int k = 1; k <= 8; k++) stepCheck("glitch_b_after", 3'b001, 3'b000, 3'b000);

        // Release a
        applyStimulus(3'b000);
        for (int k = 1; k <= 5; k++) stepCheck("drop_a_wait", 3'b001, 3'b000, 3'b000);
        stepCheck("drop_a_edge6", 3'b000, 3'b000, 3'b001);
        stepCheck("drop_a_edge7", 3'b000, 3'b000, 3'b000);

        // Simultaneous rise, c drops after two cycles
        applyStimulus(3'b111);
        for (int k = 1; k <= 2; k++) stepCheck("multi_wait", 3'b000, 3'b000, 3'b000);
        applyStimulus(3'b011);
        for (int k = 3; k <= 5; k++) stepCheck("multi_wait", 3'b000, 3'b000, 3'b000);
        stepCheck("multi_edge6", 3'b011, 3'b011, 3'b000);
        for (int k = 7; k <= 10; k++) stepCheck("multi_hold", 3'b011, 3'b000, 3'b000);

        // All high, then all dropped together
        applyStimulus(3'b111);
        for (int k = 1; k <= 5; k++) stepCheck("c_up_wait", 3'b011, 3'b000, 3'b000);
        stepCheck("c_up_edge6", 3'b111, 3'b100, 3'b000);
        stepCheck("c_up_edge7", 3'b111, 3'b000, 3'b000);
        applyStimulus(3'b000);
        for (int k = 1; k <= 5; k++) stepCheck("all_down_wait", 3'b111, 3'b000, 3'b000);
        stepCheck("all_down_edge6", 3'b000, 3'b000, 3'b111);
        stepCheck("all_down_edge7", 3'b000, 3'b000, 3'b000);

        // Asynchronous reset in the middle of a count on c
        applyStimulus(3'b001);
        for (int k = 1; k <= 5; k++) stepCheck("pre_rst_wait", 3'b000, 3'b000, 3'b000);
        stepCheck("pre_rst_edge6", 3'b001, 3'b001, 3'b000);
        applyStimulus(3'b101);
        for (int k = 1; k <= 4; k++) stepCheck("mid_count", 3'b001, 3'b000, 3'b000);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_db", db, 3'b000);
        checkOutput("async_rst_rise", rise, 3'b000);
        checkOutput("async_rst_fall", fall, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) stepCheck("post_rst_wait", 3'b000, 3'b000, 3'b000);
        stepCheck("post_rst_edge6", 3'b101, 3'b101, 3'b000);
        stepCheck("post_rst_edge7", 3'b101, 3'b000, 3'b000);

        // Input chattering every cycle never settles
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_db", db, 3'b000);
        applyStimulus(3'b000);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            applyStimulus({2'b00, k[0]});
            @(posedge clk);
            #1;
            checkOutput("toggle_db", db, 3'b000);
            checkOutput("toggle_rise", rise, 3'b000);
            checkOutput("toggle_fall", fall, 3'b000);
        end
        applyStimulus(3'b000);
        for (int k = 1; k <= 6; k++) stepCheck("toggle_settle", 3'b000, 3'b000, 3'b000);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_debounce3.md
INPUT_DEBOUNCE3 -- requirements
Module: input_debounce3

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 4, number of consecutive differing synchronized samples required before an output toggles; legal range 2..65535.
REQ-002 Parameter: CNT_W, 16, counter width per channel; shall be at least clog2(DEBOUNCE_CYCLES+1).
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: a  input  1  raw asynchronous switch/button input, channel 0.
REQ-006 Port: b  input  1  raw asynchronous switch/button input, channel 1.
REQ-007 Port: c  input  1  raw asynchronous switch/button input, channel 2.
REQ-008 Port: db  output  3  debounced levels {c,b,a} (bit 0 = a); feeds the downstream 3-input OR stage directly.
REQ-009 Port: rise  output  3  one-cycle pulse per channel when db bit goes 0->1.
REQ-010 Port: fall  output  3  one-cycle pulse per channel when db bit goes 1->0.

Function
REQ-011 Each channel shall pass its raw input through a 2-flop synchronizer (s1 then s2) before any other use.
REQ-012 Each channel shall hold a counter cnt (CNT_W bits) and a registered debounced level db[i].
REQ-013 Per channel, per clock edge: s2 == db[i] -> cnt cleared to 0, db[i] held.
REQ-014 Per channel, per clock edge: s2 != db[i] and cnt < DEBOUNCE_CYCLES-1 -> cnt incremented by 1, db[i] held.
REQ-015 Per channel, per clock edge: s2 != db[i] and cnt == DEBOUNCE_CYCLES-1 -> db[i] takes s2, cnt cleared to 0.
REQ-016 Latency: raw input changed and held stable before edge 1 -> db[i] changes at edge DEBOUNCE_CYCLES+2, no earlier, no later.
REQ-017 Glitch rejection: any sample at which s2 returns to db[i] before the toggle shall clear cnt; the next difference restarts counting from 0.
REQ-018 rise[i] shall be 1 for exactly the cycle following the edge at which db[i] goes 0->1, 0 otherwise; fall[i] likewise for 1->0; both registered, never asserted together.
REQ-019 Channels shall be fully independent; simultaneous changes on several inputs shall each follow REQ-013..REQ-018 with no interaction.
REQ-020 cnt shall never exceed DEBOUNCE_CYCLES-1 and shall never wrap.
REQ-021 Inputs toggling every cycle indefinitely shall never produce a db change.

Reset
REQ-022 rst_n low shall immediately, without a clock, force s1, s2, cnt, db, rise and fall of all channels to 0.
REQ-023 Reset asserted mid-count shall discard the partial count; after release counting restarts per REQ-013..REQ-015.
REQ-024 On release with an input already high, db shall go high at edge DEBOUNCE_CYCLES+2 after release, with rise pulse per REQ-018.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 a held 1 from before edge 1 after reset -> db = 3'b001 at edge 6, rise = 3'b001 for one cycle only, db = 0 through edge 5.
REQ-026 b high for 3 synchronized cycles then low -> db[1] stays 0, rise stays 0, cnt[1] returns to 0.
REQ-027 a, b, c raised together then c dropped after 2 cycles -> db goes 3'b011 at edge 6, db[2] never set.
REQ-028 db = 3'b111, all inputs dropped -> db = 3'b000 at edge 6, fall = 3'b111 for one cycle.
REQ-029 c counting (cnt = 2), rst_n pulsed low asynchronously -> all outputs 0 immediately; c still high -> db[2] = 1 at edge 6 after release.
REQ-030 a toggling every clock for 100 cycles -> db[0], rise[0], fall[0] remain 0 throughout.
